core_lsu_ctrl: RTL and testbench

CORE_LSU_CTRL -- requirements
Module: core_lsu_ctrl

---
 rtl/core_lsu_ctrl_if.sv | 41 ++++
 rtl/core_lsu_ctrl.sv | 144 ++++++++++++++
 tb/tb_core_lsu_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core_lsu_ctrl_if.sv
// core_lsu_ctrl_if: bundles every MEM-stage, L1D and write-back signal of the
// load/store controller.
//   slave  : the controller side (core_lsu_ctrl)
//   master : the pipeline/cache side that drives requests and acks
// Signal names keep the _in/_out suffixes as seen from the controller.
interface core_lsu_ctrl_if;
    logic        mem_req_in;
    logic        mem_we_in;
    logic [1:0]  mem_size_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_wdata_in;
    logic        flush_in;

    logic        l1d_req_out;
    logic        l1d_we_out;
    logic [31:0] l1d_addr_out;
    logic [3:0]  l1d_be_out;
    logic [31:0] l1d_wdata_out;
    logic        l1d_ack_in;
    logic [31:0] l1d_rdata_in;

    logic [31:0] wb_mem_data_out;
    logic        wb_ack_out;
    logic        stall_out;
    logic        misalign_out;
    logic        timeout_err_out;

    modport slave (
        input  mem_req_in, mem_we_in, mem_size_in, mem_addr_in, mem_wdata_in,
        input  flush_in, l1d_ack_in, l1d_rdata_in,
        output l1d_req_out, l1d_we_out, l1d_addr_out, l1d_be_out, l1d_wdata_out,
        output wb_mem_data_out, wb_ack_out, stall_out, misalign_out, timeout_err_out
    );

    modport master (
        output mem_req_in, mem_we_in, mem_size_in, mem_addr_in, mem_wdata_in,
        output flush_in, l1d_ack_in, l1d_rdata_in,
        input  l1d_req_out, l1d_we_out, l1d_addr_out, l1d_be_out, l1d_wdata_out,
        input  wb_mem_data_out, wb_ack_out, stall_out, misalign_out, timeout_err_out
    );
endinterface

// File: rtl/core_lsu_ctrl.sv
// core_lsu_ctrl: single-outstanding load/store controller between the MEM
// stage and the L1 data cache.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - core_lsu_ctrl_if.slave: MEM request, L1D request/ack, WB result,
//          stall / misalign / timeout indications
// Parameter ACK_TIMEOUT (2..255): BUSY cycles allowed before giving up on ack.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an aligned, unflushed MEM request
// BUSY  | L1D request held; waiting for ack or timeout
// DONE  | one-cycle write-back pulse (data or timeout error)
module core_lsu_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input logic           clk,
    input logic           rst,
    core_lsu_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        kill_q;
    logic        tmo_pend_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] wb_data_q;

    logic        misaligned;
    logic        req_seen;
    logic        accept;
    logic        kill_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] rdata_shifted;
    logic [31:0] load_data;

    always_comb begin
        misaligned = ((bus.mem_size_in == 2'b01) && bus.mem_addr_in[0]) ||
                     (bus.mem_size_in[1] && (bus.mem_addr_in[1:0] != 2'b00));
        // Requests are only looked at in IDLE, never under flush or reset.
        req_seen   = !rst && (state_q == IDLE) && bus.mem_req_in && !bus.flush_in;
        accept     = req_seen && !misaligned;
        kill_d     = kill_q || bus.flush_in;

        case (bus.mem_size_in)
            2'b00:   be_d = 4'b0001 << bus.mem_addr_in[1:0];
            2'b01:   be_d = bus.mem_addr_in[1] ? 4'b1100 : 4'b0011;
            default: be_d = 4'b1111;
        endcase

        case (bus.mem_size_in)
            2'b00:   wdata_d = {4{bus.mem_wdata_in[7:0]}};
            2'b01:   wdata_d = {2{bus.mem_wdata_in[15:0]}};
            default: wdata_d = bus.mem_wdata_in;
        endcase

        rdata_shifted = bus.l1d_rdata_in >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_data = {24'b0, rdata_shifted[7:0]};
            2'b01:   load_data = {16'b0, rdata_shifted[15:0]};
            default: load_data = rdata_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            kill_q     <= 1'b0;
            tmo_pend_q <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= '0;
            off_q      <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q       <= bus.mem_we_in;
                        size_q     <= bus.mem_size_in;
                        off_q      <= bus.mem_addr_in[1:0];
                        addr_q     <= {bus.mem_addr_in[31:2], 2'b00};
                        be_q       <= be_d;
                        wdata_q    <= wdata_d;
                        cnt_q      <= '0;
                        kill_q     <= 1'b0;
                        tmo_pend_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    kill_q <= kill_d;
                    if (bus.l1d_ack_in) begin
                        // A killed access completes silently and keeps the old WB data.
                        if (!kill_d) begin
                            wb_data_q <= we_q ? 32'h0 : load_data;
                        end
                        state_q <= kill_d ? IDLE : DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        if (!kill_d) begin
                            wb_data_q  <= '0;
                            tmo_pend_q <= 1'b1;
                        end
                        state_q <= kill_d ? IDLE : DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    tmo_pend_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.l1d_req_out     = (state_q == BUSY);
    assign bus.l1d_we_out      = we_q;
    assign bus.l1d_addr_out    = addr_q;
    assign bus.l1d_be_out      = be_q;
    assign bus.l1d_wdata_out   = wdata_q;
    assign bus.wb_mem_data_out = wb_data_q;
    assign bus.wb_ack_out      = (state_q == DONE);
    assign bus.timeout_err_out = (state_q == DONE) && tmo_pend_q;
    // Stall is raised in the accept cycle itself so the pipeline holds MEM.
    assign bus.stall_out       = accept || (state_q == BUSY);
    assign bus.misalign_out    = req_seen && misaligned;

endmodule

// File: tb/tb_core_lsu_ctrl.sv
// tb_core_lsu_ctrl: directed and randomized checks of core_lsu_ctrl against a
// transaction-level reference model (byte-lane arithmetic per access).
module tb_core_lsu_ctrl;

    localparam int ACK_TO = 16;

    logic clk;
    logic rst;
    core_lsu_ctrl_if bus ();

    core_lsu_ctrl #(.ACK_TIMEOUT(ACK_TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_data = 32'h0;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
        int ofs = int'(a % 4);
        if (sz == 2'b00) return 4'(1 << ofs);
        if (sz == 2'b01) return (ofs >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'b00) return (w % 256) * 32'h0101_0101;
        if (sz == 2'b01) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v = rd / (32'h1 << (8 * (a % 4)));
        if (sz == 2'b00) return v % 256;
        if (sz == 2'b01) return v % 65536;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        chk1({tag, "_req"}, bus.l1d_req_out, 1'b0);
        chk1({tag, "_we"}, bus.l1d_we_out, 1'b0);
        chk32({tag, "_addr"}, bus.l1d_addr_out, 32'h0);
        chk32({tag, "_be"}, {28'h0, bus.l1d_be_out}, 32'h0);
        chk32({tag, "_wdata"}, bus.l1d_wdata_out, 32'h0);
        chk32({tag, "_wbdata"}, bus.wb_mem_data_out, 32'h0);
        chk1({tag, "_wback"}, bus.wb_ack_out, 1'b0);
        chk1({tag, "_stall"}, bus.stall_out, 1'b0);
        chk1({tag, "_mis"}, bus.misalign_out, 1'b0);
        chk1({tag, "_tmo"}, bus.timeout_err_out, 1'b0);
    endtask

    // One MEM access from its request cycle through write-back (or kill).
    // ack_dly: BUSY cycle index carrying the ack (>= ACK_TO means never).
    // flush_at: BUSY cycle index carrying flush_in (-1 means none).
    task automatic do_txn(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input int ack_dly, input logic [31:0] rd,
                          input int flush_at);
        bit mis;
        bit acked;
        bit killed;
        logic [31:0] a_al;
        mis    = (sz == 2'b01 && (addr % 2) != 0) || (sz >= 2'd2 && (addr % 4) != 0);
        acked  = 0;
        killed = 0;
        a_al   = addr - (addr % 4);

        step();
        bus.mem_req_in   = 1'b1;
        bus.mem_we_in    = we;
        bus.mem_size_in  = sz;
        bus.mem_addr_in  = addr;
        bus.mem_wdata_in = wd;
        bus.flush_in     = 1'b0;
        bus.l1d_ack_in   = 1'b0;
        #2;
        chk1("t0_stall", bus.stall_out, !mis);
        chk1("t0_misalign", bus.misalign_out, mis);
        chk1("t0_l1d_req", bus.l1d_req_out, 1'b0);

        if (mis) begin
            step();
            bus.mem_req_in = 1'b0;
            #2;
            chk1("mis_next_req", bus.l1d_req_out, 1'b0);
            chk1("mis_next_stall", bus.stall_out, 1'b0);
            chk1("mis_next_pulse", bus.misalign_out, 1'b0);
            return;
        end

        for (int k = 0; k < ACK_TO; k++) begin
            step();
            bus.mem_req_in   = 1'b0;
            bus.mem_we_in    = 1'($urandom);
            bus.mem_size_in  = 2'($urandom);
            bus.mem_addr_in  = $urandom;
            bus.mem_wdata_in = $urandom;
            bus.flush_in     = (k == flush_at);
            bus.l1d_ack_in   = (k == ack_dly);
            bus.l1d_rdata_in = (k == ack_dly) ? rd : $urandom;
            #2;
            if (k == flush_at) killed = 1;
            chk1("busy_req", bus.l1d_req_out, 1'b1);
            chk1("busy_stall", bus.stall_out, 1'b1);
            chk1("busy_we", bus.l1d_we_out, we);
            chk32("busy_addr", bus.l1d_addr_out, a_al);
            chk32("busy_be", {28'h0, bus.l1d_be_out}, {28'h0, ref_be(sz, addr)});
            chk32("busy_wdata", bus.l1d_wdata_out, ref_wdata(sz, wd));
            chk1("busy_wback", bus.wb_ack_out, 1'b0);
            if (k == ack_dly) begin
                acked = 1;
                break;
            end
        end

        step();
        bus.l1d_ack_in = 1'b0;
        bus.flush_in   = 1'b0;
        if (killed) begin
            bus.mem_req_in = 1'b0;
            #2;
            chk1("kill_wback", bus.wb_ack_out, 1'b0);
            chk1("kill_tmo", bus.timeout_err_out, 1'b0);
            chk1("kill_req", bus.l1d_req_out, 1'b0);
            chk1("kill_stall", bus.stall_out, 1'b0);
            chk32("kill_wbdata", bus.wb_mem_data_out, exp_data);
        end else begin
            // A request presented during DONE must be ignored.
            bus.mem_req_in  = 1'b1;
            bus.mem_size_in = 2'b10;
            bus.mem_addr_in = 32'h0000_0100;
            exp_data = acked ? (we ? 32'h0 : ref_load(sz, addr, rd)) : 32'h0;
            #2;
            chk1("done_wback", bus.wb_ack_out, 1'b1);
            chk1("done_tmo", bus.timeout_err_out, !acked);
            chk32("done_wbdata", bus.wb_mem_data_out, exp_data);
            chk1("done_req", bus.l1d_req_out, 1'b0);
            chk1("done_stall", bus.stall_out, 1'b0);
            #4;
            bus.mem_req_in = 1'b0;
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.mem_req_in   = 1'b0;
        bus.mem_we_in    = 1'b0;
        bus.mem_size_in  = 2'b00;
        bus.mem_addr_in  = 32'h0;
        bus.mem_wdata_in = 32'h0;
        bus.flush_in     = 1'b0;
        bus.l1d_ack_in   = 1'b0;
        bus.l1d_rdata_in = 32'h0;

        repeat (3) step();
        #2;
        check_all_zero("reset");
        rst = 1'b0;

        // Byte load 0x1003, ack in the first BUSY cycle.
        do_txn(1'b0, 2'b00, 32'h0000_1003, 32'h0, 0, 32'hAB00_0000, -1);
        chk32("byte_load_val", bus.wb_mem_data_out, 32'h0000_00AB);

        // Half store 0x2002, two wait cycles.
        do_txn(1'b1, 2'b01, 32'h0000_2002, 32'h0000_1234, 2, 32'hFFFF_FFFF, -1);

        // Word load misaligned.
        do_txn(1'b0, 2'b10, 32'h0000_3001, 32'h0, 0, 32'h0, -1);

        // No ack: full timeout.
        do_txn(1'b0, 2'b10, 32'h0000_4000, 32'h0, 99, 32'h0, -1);

        // Load a known value, then flush in BUSY with ack 3 cycles later.
        do_txn(1'b0, 2'b11, 32'h0000_5004, 32'h0, 1, 32'hCAFE_F00D, -1);
        do_txn(1'b0, 2'b10, 32'h0000_6000, 32'h0, 3, 32'h1111_2222, 0);
        do_txn(1'b0, 2'b01, 32'h0000_7006, 32'h0, 0, 32'h8765_4321, -1);
        chk32("after_flush_val", bus.wb_mem_data_out, 32'h0000_8765);

        // Reset in BUSY, ack arriving the cycle after.
        step();
        bus.mem_req_in  = 1'b1;
        bus.mem_we_in   = 1'b0;
        bus.mem_size_in = 2'b10;
        bus.mem_addr_in = 32'h0000_8000;
        #2;
        chk1("rst_t0_stall", bus.stall_out, 1'b1);
        step();
        bus.mem_req_in = 1'b0;
        #2;
        chk1("rst_busy_req", bus.l1d_req_out, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst              = 1'b0;
        bus.l1d_ack_in   = 1'b1;
        bus.l1d_rdata_in = 32'hDEAD_BEEF;
        #2;
        check_all_zero("rst_busy");
        exp_data = 32'h0;
        step();
        bus.l1d_ack_in = 1'b0;
        #2;
        chk1("rst_late_wback", bus.wb_ack_out, 1'b0);
        chk32("rst_late_wbdata", bus.wb_mem_data_out, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            int ad;
            int fa;
            ad = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 6));
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            do_txn(1'($urandom), 2'($urandom), $urandom, $urandom, ad, $urandom, fa);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
